// File: rtl/logicnet_quant_pkg.sv
// logicnet_quant_pkg: shared state encoding and threshold helpers for the input quantizer
package logicnet_quant_pkg;
  typedef enum logic [1:0] {COLLECT, FULL, DROP} state_t;
  function automatic int num_thresh(input int q_bits);
    return (1 << q_bits) - 1;
  endfunction
  // k is zero-based, so threshold k sits at (k+1) equal steps of the input range
  function automatic logic [63:0] default_thresh(input int feat_w, input int q_bits, input int k);
    return 64'(k + 1) << (feat_w - q_bits);
  endfunction
endpackage

// File: rtl/logicnet_thresh_cmp.sv
// logicnet_thresh_cmp: counts how many of one feature's thresholds a sample meets or exceeds
module logicnet_thresh_cmp import logicnet_quant_pkg::*; #(
  parameter int FEAT_W = 16,
  parameter int Q_BITS = 2,
  parameter int T = num_thresh(Q_BITS)
) (
  input  logic [FEAT_W-1:0]   data,
  input  logic [T*FEAT_W-1:0] thresh,
  output logic [Q_BITS-1:0]   code
);
  always_comb begin
    code = '0;
    for (int k = 0; k < T; k++)
      code = code + Q_BITS'(data >= thresh[k*FEAT_W +: FEAT_W]);
  end
endmodule

// File: rtl/logicnet_input_quantizer.sv
// logicnet_input_quantizer: quantizes a framed feature stream into the packed layer0 input vector
module logicnet_input_quantizer import logicnet_quant_pkg::*; #(
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_W = 16,
  parameter int Q_BITS = 2,
  parameter int CFG_AW = $clog2(NUM_FEATURES*(2**Q_BITS-1))
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FEAT_W-1:0]              in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [NUM_FEATURES*Q_BITS-1:0] out_vec,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           cfg_we,
  input  logic [CFG_AW-1:0]              cfg_addr,
  input  logic [FEAT_W-1:0]              cfg_data,
  output logic                           frame_err
);
  localparam int T = num_thresh(Q_BITS);
  localparam int NT = NUM_FEATURES * T;
  localparam int CW = NUM_FEATURES > 1 ? $clog2(NUM_FEATURES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_FEATURES - 1);
  logic [FEAT_W-1:0]              th [NT];
  logic [T*FEAT_W-1:0]            sel_th;
  logic [Q_BITS-1:0]              code;
  logic [NUM_FEATURES*Q_BITS-1:0] asm_vec;
  logic [CW-1:0]                  cnt;
  state_t                         state, next;
  logic                           at_last, collect_beat, err, load;
  assign at_last = cnt == LAST;
  assign collect_beat = state == COLLECT && in_valid;
  // only the feature currently being collected needs a comparator
  always_comb begin
    sel_th = '0;
    for (int k = 0; k < T; k++)
      sel_th[k*FEAT_W +: FEAT_W] = th[int'(cnt)*T + k];
  end
  logicnet_thresh_cmp #(.FEAT_W(FEAT_W), .Q_BITS(Q_BITS), .T(T)) u_cmp (
    .data(in_data),
    .thresh(sel_th),
    .code(code)
  );
  always_ff @(posedge clk) begin
    if (!rst)
      for (int i = 0; i < NT; i++) th[i] <= FEAT_W'(default_thresh(FEAT_W, Q_BITS, i % T));
    else if (cfg_we && int'(cfg_addr) < NT)
      th[cfg_addr] <= cfg_data;
  end
  always_ff @(posedge clk) state <= !rst ? COLLECT : next;
  // a length error is any beat where in_last disagrees with the final slot
  always_comb begin
    next = state;
    in_ready = 1'b0;
    err = 1'b0;
    load = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        err = in_valid && (at_last != in_last);
        if (in_valid && at_last) next = in_last ? FULL : DROP;
      end
      FULL: begin
        load = !out_valid || out_ready;
        if (load) next = COLLECT;
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) next = COLLECT;
      end
      default: next = COLLECT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      asm_vec <= '0;
      out_vec <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      if (collect_beat) begin
        asm_vec[int'(cnt)*Q_BITS +: Q_BITS] <= code;
        cnt <= (in_last || at_last) ? '0 : cnt + 1'b1;
      end
      if (load) begin
        out_vec <= asm_vec;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// tb_logicnet_input_quantizer: randomized self-checking bench against a threshold-count model
module tb_logicnet_input_quantizer;
  localparam int N = 4, W = 16, Q = 2, T = 3, NT = 12, AW = 4;
  logic clk = 0, rst = 0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 0, in_last = 0, in_ready;
  logic [N*Q-1:0] out_vec;
  logic out_valid, out_ready = 0;
  logic cfg_we = 0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic frame_err;
  int checks = 0, failures = 0;
  logic [W-1:0] mth [NT];

  always #5 clk = ~clk;

  logicnet_input_quantizer #(.NUM_FEATURES(N), .FEAT_W(W), .Q_BITS(Q), .CFG_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .frame_err(frame_err)
  );

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) mth[i] = W'((i % T + 1) * (1 << (W - Q)));
  endfunction

  function automatic logic [Q-1:0] mq(input int f, input logic [W-1:0] x);
    int c = 0;
    for (int k = 0; k < T; k++) if (x >= mth[f*T+k]) c++;
    return Q'(c);
  endfunction

  function automatic logic [N*Q-1:0] mvec(input logic [W-1:0] d[$]);
    logic [N*Q-1:0] v = '0;
    for (int f = 0; f < N; f++) v[f*Q +: Q] = mq(f, d[f]);
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_sample(input int f);
    int k = $urandom_range(0, T-1);
    case ($urandom_range(0, 2))
      0: return W'($urandom);
      1: return mth[f*T+k];
      default: return mth[f*T+k] - 1'b1;
    endcase
  endfunction

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [W-1:0] d, input bit last);
    bit r;
    in_data = d; in_last = last; in_valid = 1;
    for (int i = 0; i <= 40; i++) begin
      if (i == 40) begin
        checks++; failures++;
        $display("FAIL beat_accept timeout in_ready=%b want=1", in_ready);
        break;
      end
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) break;
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic send(input logic [W-1:0] d[$]);
    for (int i = 0; i < d.size(); i++) beat(d[i], i == d.size() - 1);
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [W-1:0] v);
    cfg_we = 1; cfg_addr = a; cfg_data = v;
    cycle(1);
    cfg_we = 0;
    if (int'(a) < NT) mth[a] = v;
  endtask

  task automatic rnd_frame(output logic [W-1:0] d[$]);
    d = {};
    for (int f = 0; f < N; f++) d.push_back(rnd_sample(f));
  endtask

  task automatic test_reset();
    rst = 0; cycle(2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_vec !== '0) begin failures++; $display("FAIL reset_out_vec got=%h want=00", out_vec); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    rst = 1; model_reset();
    cycle(1);
  endtask

  task automatic test_basic();
    logic [W-1:0] d[$] = '{16'h0000, 16'h4000, 16'hBFFF, 16'hFFFF};
    out_ready = 0;
    send(d);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_early got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_full_in_ready got=%b want=0", in_ready); end
    cycle(1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
    checks++; if (out_vec !== 8'b11_10_01_00) begin failures++; $display("FAIL basic_out_vec got=%b want=11100100", out_vec); end
    out_ready = 1; cycle(1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b want=0", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_cfg();
    logic [W-1:0] d[$];
    logic [N*Q-1:0] exp;
    logic [Q-1:0] e0;
    out_ready = 1;
    cfg_write(0, 16'h0010);
    d = '{16'h000F, 16'h0010, 16'h0000, 16'h0000};
    exp = mvec(d);
    send(d); cycle(1);
    checks++; if (out_vec[1:0] !== 2'd0) begin failures++; $display("FAIL cfg_code_below got=%0d want=0", out_vec[1:0]); end
    checks++; if (out_valid !== 1'b1 || out_vec !== exp) begin failures++; $display("FAIL cfg_frame1 got=%b/%h want=1/%h", out_valid, out_vec, exp); end
    d = '{16'h0010, rnd_sample(1), rnd_sample(2), rnd_sample(3)};
    exp = mvec(d);
    send(d); cycle(1);
    checks++; if (out_vec[1:0] !== 2'd1) begin failures++; $display("FAIL cfg_code_at got=%0d want=1", out_vec[1:0]); end
    checks++; if (out_valid !== 1'b1 || out_vec !== exp) begin failures++; $display("FAIL cfg_frame2 got=%b/%h want=1/%h", out_valid, out_vec, exp); end
    rnd_frame(d);
    e0 = mq(0, d[0]);
    beat(d[0], 0);
    cfg_write(AW'(0), W'($urandom));
    cfg_write(AW'(9), W'($urandom));
    d[3] = rnd_sample(3);
    beat(d[1], 0); beat(d[2], 0); beat(d[3], 1);
    exp = mvec(d); exp[1:0] = e0;
    cycle(1);
    checks++; if (out_valid !== 1'b1 || out_vec !== exp) begin failures++; $display("FAIL cfg_midframe got=%b/%h want=1/%h", out_valid, out_vec, exp); end
    cycle(1);
  endtask

  task automatic test_random();
    logic [W-1:0] d[$];
    logic [N*Q-1:0] exp;
    out_ready = 1;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1)) cfg_write(AW'($urandom_range(0, 15)), W'($urandom));
      rnd_frame(d);
      exp = mvec(d);
      send(d); cycle(1);
      checks++; if (out_valid !== 1'b1 || out_vec !== exp) begin failures++; $display("FAIL random_frame%0d got=%b/%h want=1/%h", n, out_valid, out_vec, exp); end
    end
    cycle(1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL random_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a[$], b[$];
    logic [N*Q-1:0] ea, eb;
    out_ready = 0;
    rnd_frame(a); rnd_frame(b);
    ea = mvec(a); eb = mvec(b);
    send(a); cycle(1);
    checks++; if (out_valid !== 1'b1 || out_vec !== ea) begin failures++; $display("FAIL b2b_a got=%b/%h want=1/%h", out_valid, out_vec, ea); end
    send(b);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b want=0", in_ready); end
    cycle(1);
    checks++; if (in_ready !== 1'b0 || out_vec !== ea) begin failures++; $display("FAIL b2b_hold got=%b/%h want=0/%h", in_ready, out_vec, ea); end
    out_ready = 1; cycle(1);
    checks++; if (out_valid !== 1'b1 || out_vec !== eb) begin failures++; $display("FAIL b2b_swap got=%b/%h want=1/%h", out_valid, out_vec, eb); end
    cycle(1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_short();
    logic [W-1:0] d[$];
    logic [N*Q-1:0] exp;
    bit seen = 0;
    out_ready = 1;
    beat(W'($urandom), 0); beat(W'($urandom), 1);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL short_err got=%b want=1", frame_err); end
    cycle(1);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL short_err_pulse got=%b want=0", frame_err); end
    for (int i = 0; i < 3; i++) begin seen |= out_valid; cycle(1); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL short_no_output got=%b want=0", seen); end
    rnd_frame(d); exp = mvec(d);
    send(d); cycle(1);
    checks++; if (out_valid !== 1'b1 || out_vec !== exp) begin failures++; $display("FAIL short_next got=%b/%h want=1/%h", out_valid, out_vec, exp); end
    cycle(1);
  endtask

  task automatic test_long();
    logic [W-1:0] d[$];
    logic [N*Q-1:0] exp;
    bit seen = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) beat(W'($urandom), 0);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL long_err got=%b want=1", frame_err); end
    beat(W'($urandom), 0);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL long_err_pulse got=%b want=0", frame_err); end
    beat(W'($urandom), 1);
    checks++; if (in_ready !== 1'b1 || frame_err !== 1'b0) begin failures++; $display("FAIL long_resume got=%b/%b want=1/0", in_ready, frame_err); end
    for (int i = 0; i < 3; i++) begin seen |= out_valid; cycle(1); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL long_no_output got=%b want=0", seen); end
    rnd_frame(d); exp = mvec(d);
    send(d); cycle(1);
    checks++; if (out_valid !== 1'b1 || out_vec !== exp) begin failures++; $display("FAIL long_next got=%b/%h want=1/%h", out_valid, out_vec, exp); end
    cycle(1);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d[$];
    logic [N*Q-1:0] exp;
    out_ready = 0;
    cfg_write(3, 16'h0000);
    rnd_frame(d);
    send(d); cycle(1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_loaded got=%b want=1", out_valid); end
    beat(W'($urandom), 0); beat(W'($urandom), 0);
    rst = 0; cycle(1); rst = 1;
    model_reset();
    checks++; if (out_valid !== 1'b0 || out_vec !== '0) begin failures++; $display("FAIL rstmid_out got=%b/%h want=0/00", out_valid, out_vec); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    d = '{16'h3FFF, 16'h0001, 16'h8000, 16'hC000};
    exp = mvec(d);
    out_ready = 1;
    send(d); cycle(1);
    checks++; if (out_valid !== 1'b1 || out_vec !== exp) begin failures++; $display("FAIL rstmid_next got=%b/%h want=1/%h", out_valid, out_vec, exp); end
    cycle(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_cfg();
    test_random();
    test_back_to_back();
    test_short();
    test_long();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
